// File: rtl/dram_sched_pkg.sv
// Shared types and default timing for the DRAM cycle scheduler.
// The delay counter width is fixed at 3 bits, so each timing parameter must be 8 or less.
package dram_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAS,
    ST_COL,
    ST_CAS,
    ST_HOLD,
    ST_REFC,
    ST_REFR,
    ST_PRE
  } dram_st_t;

  localparam int TRP_DEF  = 2;
  localparam int TCAS_DEF = 2;
  localparam int TRAS_DEF = 3;
  localparam int CNT_W    = 3;

  // A state lasting N cycles loads N-1 and leaves when the counter reads zero.
  function automatic logic [CNT_W-1:0] cnt_init(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/dram_dly_cnt.sv
// Loadable 3-bit down-counter that sets the length of the CAS, REFR and PRE states.
// It holds at zero once it gets there.
module dram_dly_cnt
  import dram_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= val;
    else if (!zero)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/dram_sched.sv
// Scheduler for DRAM access and CAS-before-RAS refresh cycles on the FSB clock.
// Every pin is a flop, loaded from a decode of the next state.
module dram_sched
  import dram_sched_pkg::*;
#(
  parameter int TRP  = TRP_DEF,
  parameter int TCAS = TCAS_DEF,
  parameter int TRAS = TRAS_DEF
) (
  input  logic CLK,
  input  logic RES,
  input  logic BACT,
  input  logic RAMCS,
  input  logic RefReq,
  input  logic RefUrg,
  output logic nRAS,
  output logic nCAS,
  output logic RASEL,
  output logic RAMReady,
  output logic RefAck
);

  dram_st_t         st, st_nxt;
  logic             load;
  logic [CNT_W-1:0] val, cnt, cnt_nxt;
  logic             zero;
  logic             acc_req;

  assign acc_req = BACT & RAMCS;

  dram_dly_cnt u_dly (
    .clk  (CLK),
    .rst  (RES),
    .load (load),
    .val  (val),
    .cnt  (cnt),
    .zero (zero)
  );

  always_comb begin
    st_nxt = st;
    load   = 1'b0;
    val    = '0;
    case (st)
      ST_IDLE: begin
        // An urgent refresh goes ahead of a pending access. The access is not lost:
        // BACT&RAMCS is still high when the scheduler returns to IDLE.
        if (RefUrg)
          st_nxt = ST_REFC;
        else if (acc_req)
          st_nxt = ST_RAS;
        else if (RefReq)
          st_nxt = ST_REFC;
      end
      ST_RAS: st_nxt = ST_COL;
      ST_COL: begin
        st_nxt = ST_CAS;
        load   = 1'b1;
        val    = cnt_init(TCAS);
      end
      ST_CAS: begin
        if (zero) begin
          if (BACT) begin
            st_nxt = ST_HOLD;
          end else begin
            st_nxt = ST_PRE;
            load   = 1'b1;
            val    = cnt_init(TRP);
          end
        end
      end
      ST_HOLD: begin
        if (!BACT) begin
          st_nxt = ST_PRE;
          load   = 1'b1;
          val    = cnt_init(TRP);
        end
      end
      ST_REFC: begin
        st_nxt = ST_REFR;
        load   = 1'b1;
        val    = cnt_init(TRAS);
      end
      ST_REFR: begin
        if (zero) begin
          st_nxt = ST_PRE;
          load   = 1'b1;
          val    = cnt_init(TRP);
        end
      end
      ST_PRE: begin
        if (zero)
          st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // The counter value for the next cycle lets RAMReady be registered for the last CAS cycle.
  assign cnt_nxt = load ? val : (zero ? cnt : cnt - 1'b1);

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      st       <= ST_IDLE;
      nRAS     <= 1'b1;
      nCAS     <= 1'b1;
      RASEL    <= 1'b0;
      RAMReady <= 1'b0;
      RefAck   <= 1'b0;
    end else begin
      st       <= st_nxt;
      nRAS     <= !(st_nxt inside {ST_RAS, ST_COL, ST_CAS, ST_HOLD, ST_REFR});
      nCAS     <= !(st_nxt inside {ST_CAS, ST_HOLD, ST_REFC, ST_REFR});
      RASEL    <= (st_nxt inside {ST_COL, ST_CAS, ST_HOLD});
      RAMReady <= ((st_nxt == ST_CAS) && (cnt_nxt == '0)) || (st_nxt == ST_HOLD);
      RefAck   <= (st == ST_REFR) && (st_nxt == ST_PRE);
    end
  end

endmodule

// File: tb/tb_dram_sched.sv
// Directed bench for dram_sched at default timing. It checks the output vector
// {nRAS,nCAS,RASEL,RAMReady,RefAck} after each clock edge against values worked out by hand.
module tb_dram_sched;

  logic CLK = 1'b0;
  logic RES, BACT, RAMCS, RefReq, RefUrg;
  logic nRAS, nCAS, RASEL, RAMReady, RefAck;
  logic [4:0] outv;
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [4:0] IDLEV = 5'b11000;

  dram_sched dut (
    .CLK      (CLK),
    .RES      (RES),
    .BACT     (BACT),
    .RAMCS    (RAMCS),
    .RefReq   (RefReq),
    .RefUrg   (RefUrg),
    .nRAS     (nRAS),
    .nCAS     (nCAS),
    .RASEL    (RASEL),
    .RAMReady (RAMReady),
    .RefAck   (RefAck)
  );

  always #5 CLK = ~CLK;

  assign outv = {nRAS, nCAS, RASEL, RAMReady, RefAck};

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RES = 1'b1; BACT = 1'b0; RAMCS = 1'b0; RefReq = 1'b0; RefUrg = 1'b0;
    step();
    step();
    n_cmp++;
    if (outv !== IDLEV) begin
      n_err++;
      $display("FAIL reset_held: got %b want %b", outv, IDLEV);
    end
    RES = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if (outv !== IDLEV) begin
        n_err++;
        $display("FAIL reset_idle edge %0d: got %b want %b", k, outv, IDLEV);
      end
    end
  endtask

  // One access with BACT dropped at edge 6, then a second one requested while in PRE.
  // The second RAS cannot start before edge 9.
  task automatic test_single_access();
    logic       bv  [16] = '{1,1,1,1,1,1,0,1,1,1,0,0,0,0,0,0};
    logic [4:0] exv [16] = '{5'b01000, 5'b01100, 5'b00100, 5'b00110,
                             5'b00110, 5'b00110, 5'b11000, 5'b11000,
                             5'b11000, 5'b01000, 5'b01100, 5'b00100,
                             5'b00110, 5'b11000, 5'b11000, 5'b11000};
    RAMCS = 1'b1;
    for (int k = 0; k < 16; k++) begin
      BACT = bv[k];
      step();
      n_cmp++;
      if (outv !== exv[k]) begin
        n_err++;
        $display("FAIL single_access edge %0d: got %b want %b", k, outv, exv[k]);
      end
    end
    RAMCS = 1'b0;
  endtask

  task automatic test_aborted();
    logic       bv  [8] = '{1,0,0,0,0,0,0,0};
    logic [4:0] exv [8] = '{5'b01000, 5'b01100, 5'b00100, 5'b00110,
                            5'b11000, 5'b11000, 5'b11000, 5'b11000};
    RAMCS = 1'b1;
    for (int k = 0; k < 8; k++) begin
      BACT = bv[k];
      step();
      n_cmp++;
      if (outv !== exv[k]) begin
        n_err++;
        $display("FAIL aborted edge %0d: got %b want %b", k, outv, exv[k]);
      end
    end
    RAMCS = 1'b0;
  endtask

  task automatic test_idle_refresh();
    logic       rv  [8] = '{1,1,1,1,1,0,0,0};
    logic [4:0] exv [8] = '{5'b10000, 5'b00000, 5'b00000, 5'b00000,
                            5'b11001, 5'b11000, 5'b11000, 5'b11000};
    for (int k = 0; k < 8; k++) begin
      RefReq = rv[k];
      step();
      n_cmp++;
      if (outv !== exv[k]) begin
        n_err++;
        $display("FAIL idle_refresh edge %0d: got %b want %b", k, outv, exv[k]);
      end
    end
  endtask

  // Access and a non-urgent refresh request arrive on the same edge.
  // The access runs first and the refresh follows it.
  task automatic test_back_to_back();
    logic       bv  [14] = '{1,1,1,1,0,0,0,0,0,0,0,0,0,0};
    logic       rv  [14] = '{1,1,1,1,1,1,1,1,1,1,1,1,0,0};
    logic [4:0] exv [14] = '{5'b01000, 5'b01100, 5'b00100, 5'b00110,
                             5'b11000, 5'b11000, 5'b11000, 5'b10000,
                             5'b00000, 5'b00000, 5'b00000, 5'b11001,
                             5'b11000, 5'b11000};
    RAMCS = 1'b1;
    for (int k = 0; k < 14; k++) begin
      BACT   = bv[k];
      RefReq = rv[k];
      step();
      n_cmp++;
      if (outv !== exv[k]) begin
        n_err++;
        $display("FAIL back_to_back edge %0d: got %b want %b", k, outv, exv[k]);
      end
    end
    RAMCS = 1'b0; BACT = 1'b0; RefReq = 1'b0;
  endtask

  // An urgent refresh pre-empts a simultaneous access. The access is held off:
  // RAMReady stays low while the refresh and its precharge run, then the access starts.
  task automatic test_urgent_defer();
    logic       bv  [12] = '{1,1,1,1,1,1,1,1,1,1,1,0};
    logic       rv  [12] = '{1,1,1,1,1,0,0,0,0,0,0,0};
    logic [4:0] exv [12] = '{5'b10000, 5'b00000, 5'b00000, 5'b00000,
                             5'b11001, 5'b11000, 5'b11000, 5'b01000,
                             5'b01100, 5'b00100, 5'b00110, 5'b11000};
    RAMCS = 1'b1;
    for (int k = 0; k < 12; k++) begin
      BACT   = bv[k];
      RefReq = rv[k];
      RefUrg = rv[k];
      step();
      n_cmp++;
      if (outv !== exv[k]) begin
        n_err++;
        $display("FAIL urgent_defer edge %0d: got %b want %b", k, outv, exv[k]);
      end
    end
    RAMCS = 1'b0; BACT = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid_refresh();
    RefReq = 1'b1;
    step();
    step();
    step();
    n_cmp++;
    if (outv !== 5'b00000) begin
      n_err++;
      $display("FAIL refr_before_reset: got %b want %b", outv, 5'b00000);
    end
    RES = 1'b1;
    RefReq = 1'b0;
    #1;
    n_cmp++;
    if (outv !== IDLEV) begin
      n_err++;
      $display("FAIL async_reset: got %b want %b", outv, IDLEV);
    end
    step();
    RES = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (outv !== IDLEV) begin
        n_err++;
        $display("FAIL post_reset edge %0d: got %b want %b", k, outv, IDLEV);
      end
    end
    RAMCS = 1'b1;
    BACT  = 1'b1;
    step();
    n_cmp++;
    if (outv !== 5'b01000) begin
      n_err++;
      $display("FAIL post_reset_ras: got %b want %b", outv, 5'b01000);
    end
    BACT = 1'b0;
    RAMCS = 1'b0;
    for (int k = 0; k < 8; k++) step();
  endtask

  initial begin
    test_reset();
    test_single_access();
    test_aborted();
    test_idle_refresh();
    test_back_to_back();
    test_urgent_defer();
    test_reset_mid_refresh();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
